// File: rtl/store_chk_pkg.sv
// Shared types for the store-sequence checker: FSM states, fail codes and
// an index-width helper that stays legal for a single-entry table.
package store_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } chkStateT;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_ADDR    = 3'd1;
    localparam logic [2:0] FC_DATA    = 3'd2;
    localparam logic [2:0] FC_TIMEOUT = 3'd3;
    localparam logic [2:0] FC_ORDER   = 3'd4;

    function automatic int idxWidth(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/store_match_unit.sv
// Combinational classifier: decides whether one store hits the expected
// table, is ignored, or fails, and with which code.
module store_match_unit
    import store_chk_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               DEPTH       = 4,
    parameter bit               ORDERED     = 1'b1,
    parameter logic [XLEN-1:0]  IGNORE_ADDR = 100
) (
    input  logic [XLEN-1:0]             storeAddr,
    input  logic [XLEN-1:0]             storeData,
    input  logic [DEPTH-1:0][XLEN-1:0]  tableAddr,
    input  logic [DEPTH-1:0][XLEN-1:0]  tableData,
    input  logic [DEPTH-1:0]            hitMask,
    input  logic [$clog2(DEPTH):0]      ptr,
    input  logic [$clog2(DEPTH):0]      len,
    output logic                        hit,
    output logic [idxWidth(DEPTH)-1:0]  hit_idx,
    output logic                        ignore,
    output logic [2:0]                  fail_code
);

    localparam int IW = idxWidth(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ordHit, ordAddrEq, ordLater;
    logic [IW-1:0] ordIdx;
    logic          unoHit, unoDup, unoAddrAny;
    logic [IW-1:0] unoIdx;

    // Both policies are evaluated side by side; ORDERED only picks the result.
    always_comb begin
        ordHit     = 1'b0;
        ordAddrEq  = 1'b0;
        ordLater   = 1'b0;
        ordIdx     = '0;
        unoHit     = 1'b0;
        unoDup     = 1'b0;
        unoAddrAny = 1'b0;
        unoIdx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < len && tableAddr[i] == storeAddr) begin
                if (CW'(i) == ptr) begin
                    ordAddrEq = 1'b1;
                    if (tableData[i] == storeData) begin
                        ordHit = 1'b1;
                        ordIdx = IW'(i);
                    end
                end else if (CW'(i) > ptr) begin
                    ordLater = 1'b1;
                end
                unoAddrAny = 1'b1;
                if (tableData[i] == storeData) begin
                    if (hitMask[i]) begin
                        unoDup = 1'b1;
                    end else if (!unoHit) begin
                        // lowest unhit index wins on duplicated table entries
                        unoHit = 1'b1;
                        unoIdx = IW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        ignore    = 1'b0;
        fail_code = FC_NONE;
        if (storeAddr == IGNORE_ADDR) begin
            ignore = 1'b1;
        end else if (ORDERED) begin
            if (ordHit) begin
                hit     = 1'b1;
                hit_idx = ordIdx;
            end else if (ordAddrEq) begin
                fail_code = FC_DATA;
            end else if (ordLater) begin
                fail_code = FC_ORDER;
            end else begin
                fail_code = FC_ADDR;
            end
        end else begin
            if (unoHit) begin
                hit     = 1'b1;
                hit_idx = unoIdx;
            end else if (unoDup) begin
                ignore = 1'b1;
            end else if (unoAddrAny) begin
                fail_code = FC_DATA;
            end else begin
                fail_code = FC_ADDR;
            end
        end
    end

endmodule

// File: rtl/store_seq_checker.sv
// Watches core stores against a programmable expected-store table and
// reports done/pass with a fail code; holds the table, FSM and counters.
module store_seq_checker
    import store_chk_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               DEPTH       = 4,
    parameter int               TIMEOUT     = 64,
    parameter bit               ORDERED     = 1'b1,
    parameter logic [XLEN-1:0]  IGNORE_ADDR = 100
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            mem_write,
    input  logic [XLEN-1:0]                 data_adr,
    input  logic [XLEN-1:0]                 write_data,
    input  logic                            exp_we,
    input  logic [idxWidth(DEPTH)-1:0]      exp_idx,
    input  logic [XLEN-1:0]                 exp_addr,
    input  logic [XLEN-1:0]                 exp_data,
    input  logic [$clog2(DEPTH):0]          exp_len,
    input  logic                            start,
    output logic                            done,
    output logic                            pass,
    output logic [2:0]                      fail_code,
    output logic [$clog2(DEPTH):0]          match_count,
    output logic [$clog2(TIMEOUT+1)-1:0]    cycles
);

    localparam int IW = idxWidth(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    chkStateT                   state, stateNext;
    logic [DEPTH-1:0][XLEN-1:0] tableAddr, tableData;
    logic [DEPTH-1:0]           hitMask;
    logic [CW-1:0]              lenQ, lenClamped;
    logic [2:0]                 failNext, unitFail;
    logic                       hit, ignore;
    logic [IW-1:0]              hitIdx;
    logic                       arm, storeHit, storeFail, completing, timeoutNow;
    logic [TW-1:0]              cycNext;

    store_match_unit #(
        .XLEN        (XLEN),
        .DEPTH       (DEPTH),
        .ORDERED     (ORDERED),
        .IGNORE_ADDR (IGNORE_ADDR)
    ) u_match (
        .storeAddr (data_adr),
        .storeData (write_data),
        .tableAddr (tableAddr),
        .tableData (tableData),
        .hitMask   (hitMask),
        .ptr       (match_count),
        .len       (lenQ),
        .hit       (hit),
        .hit_idx   (hitIdx),
        .ignore    (ignore),
        .fail_code (unitFail)
    );

    assign lenClamped = (exp_len > CW'(DEPTH)) ? CW'(DEPTH) : exp_len;
    assign arm        = start && (state != RUN);
    assign storeHit   = mem_write && hit && (lenQ != '0);
    assign storeFail  = mem_write && !hit && !ignore;
    assign completing = (lenQ == '0) || (storeHit && (match_count + CW'(1) == lenQ));
    assign cycNext    = cycles + TW'(1);
    assign timeoutNow = (cycNext == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // A store failure outranks the timeout; a completing hit outranks it too.
    always_comb begin
        stateNext = state;
        failNext  = fail_code;
        unique case (state)
            IDLE: if (start) stateNext = RUN;
            RUN: begin
                if (lenQ == '0) begin
                    stateNext = PASS;
                end else if (storeFail) begin
                    stateNext = FAIL;
                    failNext  = unitFail;
                end else if (completing) begin
                    stateNext = PASS;
                end else if (timeoutNow) begin
                    stateNext = FAIL;
                    failNext  = FC_TIMEOUT;
                end
            end
            PASS, FAIL: if (start) stateNext = RUN;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tableAddr   <= '0;
            tableData   <= '0;
            hitMask     <= '0;
            lenQ        <= '0;
            match_count <= '0;
            cycles      <= '0;
            fail_code   <= FC_NONE;
        end else begin
            if (state == IDLE && exp_we) begin
                tableAddr[exp_idx] <= exp_addr;
                tableData[exp_idx] <= exp_data;
            end
            if (arm) begin
                lenQ        <= lenClamped;
                match_count <= '0;
                cycles      <= '0;
                hitMask     <= '0;
                fail_code   <= FC_NONE;
            end else if (state == RUN) begin
                cycles    <= cycNext;
                fail_code <= failNext;
                if (storeHit) begin
                    match_count     <= match_count + CW'(1);
                    hitMask[hitIdx] <= 1'b1;
                end
            end
        end
    end

    assign done = (state == PASS) || (state == FAIL);
    assign pass = (state == PASS);

endmodule

// File: tb/tb_store_seq_checker.sv
// Bench for store_seq_checker: ordered and unordered instances share stimulus
// and are compared every cycle against a queue/array-level model of the rules.
module tb_store_seq_checker;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_PASS = 2, PH_FAIL = 3;

    logic        clk = 1'b0;
    logic        reset, mem_write, exp_we, start;
    logic [31:0] data_adr, write_data, exp_addr, exp_data;
    logic [1:0]  exp_idx;
    logic [2:0]  exp_len;
    logic        doneO, passO, doneU, passU;
    logic [2:0]  fcO, fcU, mcO, mcU;
    logic [6:0]  cycO, cycU;

    int checks = 0;
    int errors = 0;

    store_seq_checker #(.ORDERED(1'b1)) dutO (
        .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_len(exp_len), .start(start),
        .done(doneO), .pass(passO), .fail_code(fcO), .match_count(mcO), .cycles(cycO)
    );

    store_seq_checker #(.ORDERED(1'b0)) dutU (
        .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_len(exp_len), .start(start),
        .done(doneU), .pass(passU), .fail_code(fcU), .match_count(mcU), .cycles(cycU)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 ordered, 1 unordered) ----
    logic [31:0] mAddr [2][DEPTH];
    logic [31:0] mData [2][DEPTH];
    bit          mHit  [2][DEPTH];
    int          mPhase[2], mLen[2], mMatch[2], mCyc[2], mFc[2];
    bit          modelLive = 1'b0;

    // returns -1 ignored, 0 hit (idx set), >0 fail code
    function automatic int classify(int k, logic [31:0] a, logic [31:0] d, output int idx);
        int e;
        idx = -1;
        if (a == 32'd100) return -1;
        if (k == 0) begin
            e = mMatch[k];
            if (mAddr[k][e] == a && mData[k][e] == d) begin
                idx = e;
                return 0;
            end
            if (mAddr[k][e] == a) return 2;
            for (int j = e + 1; j < mLen[k]; j++)
                if (mAddr[k][j] == a) return 4;
            return 1;
        end
        for (int j = 0; j < mLen[k]; j++)
            if (mAddr[k][j] == a && mData[k][j] == d && !mHit[k][j]) begin
                idx = j;
                return 0;
            end
        for (int j = 0; j < mLen[k]; j++)
            if (mAddr[k][j] == a && mData[k][j] == d) return -1;
        for (int j = 0; j < mLen[k]; j++)
            if (mAddr[k][j] == a) return 2;
        return 1;
    endfunction

    task automatic armModel(int k);
        mLen[k]   = (exp_len > DEPTH) ? DEPTH : int'(exp_len);
        mMatch[k] = 0;
        mCyc[k]   = 0;
        mFc[k]    = 0;
        mPhase[k] = PH_RUN;
        for (int j = 0; j < DEPTH; j++) mHit[k][j] = 1'b0;
    endtask

    task automatic modelStep(int k);
        int r, idx;
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                mAddr[k][j] = '0;
                mData[k][j] = '0;
                mHit[k][j]  = 1'b0;
            end
            mPhase[k] = PH_IDLE;
            mLen[k] = 0; mMatch[k] = 0; mCyc[k] = 0; mFc[k] = 0;
            return;
        end
        case (mPhase[k])
            PH_IDLE: begin
                if (exp_we) begin
                    mAddr[k][exp_idx] = exp_addr;
                    mData[k][exp_idx] = exp_data;
                end
                if (start) armModel(k);
            end
            PH_RUN: begin
                mCyc[k]++;
                if (mLen[k] == 0) begin
                    mPhase[k] = PH_PASS;
                end else begin
                    if (mem_write) begin
                        r = classify(k, data_adr, write_data, idx);
                        if (r > 0) begin
                            mPhase[k] = PH_FAIL;
                            mFc[k]    = r;
                        end else if (r == 0) begin
                            mHit[k][idx] = 1'b1;
                            mMatch[k]++;
                            if (mMatch[k] == mLen[k]) mPhase[k] = PH_PASS;
                        end
                    end
                    if (mPhase[k] == PH_RUN && mCyc[k] == TIMEOUT) begin
                        mPhase[k] = PH_FAIL;
                        mFc[k]    = 3;
                    end
                end
            end
            default: if (start) armModel(k);
        endcase
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) modelStep(k);
        modelLive = 1'b1;
    end

    always @(negedge clk) begin
        if (modelLive) begin
            check("O.done",  doneO, mPhase[0] >= PH_PASS);
            check("O.pass",  passO, mPhase[0] == PH_PASS);
            check("O.fc",    fcO,   mFc[0]);
            check("O.match", mcO,   mMatch[0]);
            check("O.cyc",   cycO,  mCyc[0]);
            check("U.done",  doneU, mPhase[1] >= PH_PASS);
            check("U.pass",  passU, mPhase[1] == PH_PASS);
            check("U.fc",    fcU,   mFc[1]);
            check("U.match", mcU,   mMatch[1]);
            check("U.cyc",   cycU,  mCyc[1]);
        end
    end

    // ---------------- stimulus helpers (inputs change on negedge) ---------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(int idx, int a, int d);
        exp_we = 1'b1; exp_idx = 2'(idx); exp_addr = 32'(a); exp_data = 32'(d);
        step();
        exp_we = 1'b0;
    endtask

    task automatic arm(int len);
        exp_len = 3'(len); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic store(int a, int d);
        mem_write = 1'b1; data_adr = 32'(a); write_data = 32'(d);
        step();
        mem_write = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic expectO(string tag, int d, int p, int fc, int mc);
        check({tag, ".O.done"}, doneO, d);
        check({tag, ".O.pass"}, passO, p);
        check({tag, ".O.fc"},   fcO,   fc);
        check({tag, ".O.mc"},   mcO,   mc);
    endtask

    task automatic expectU(string tag, int d, int p, int fc, int mc);
        check({tag, ".U.done"}, doneU, d);
        check({tag, ".U.pass"}, passU, p);
        check({tag, ".U.fc"},   fcU,   fc);
        check({tag, ".U.mc"},   mcU,   mc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; mem_write = 1'b0; exp_we = 1'b0; start = 1'b0;
        data_adr = '0; write_data = '0; exp_addr = '0; exp_data = '0;
        exp_idx = '0; exp_len = '0;
        step();
        reset = 1'b0;
        expectO("rst", 0, 0, 0, 0);
        check("rst.O.cyc", cycO, 0);

        // scratch write then the expected store
        load(0, 104, 25);
        arm(1);
        store(100, 7);
        expectO("scratch", 0, 0, 0, 0);
        store(104, 25);
        expectO("pass", 1, 1, 0, 1);
        expectU("pass", 1, 1, 0, 1);
        store(96, 25);
        expectO("passHold", 1, 1, 0, 1);

        // unexpected address, then data mismatch
        arm(1);
        store(96, 25);
        expectO("badAddr", 1, 0, 1, 0);
        expectU("badAddr", 1, 0, 1, 0);
        store(104, 25);
        expectO("badAddrHold", 1, 0, 1, 0);
        arm(1);
        store(104, 24);
        expectO("badData", 1, 0, 2, 0);
        expectU("badData", 1, 0, 2, 0);
        store(104, 25);
        expectO("badDataHold", 1, 0, 2, 0);

        // ordering
        doReset();
        load(0, 8, 1); load(1, 12, 2); load(2, 16, 3);
        arm(3);
        store(16, 3);
        expectO("order", 1, 0, 4, 0);
        expectU("anyOrd1", 0, 0, 0, 1);
        store(8, 1);
        store(8, 1);
        expectU("anyOrdDup", 0, 0, 0, 2);
        store(12, 2);
        expectU("anyOrdDone", 1, 1, 0, 3);
        expectO("orderHold", 1, 0, 4, 0);

        // timeout with no stores
        doReset();
        load(0, 104, 25);
        arm(1);
        n = 0;
        while (n < 100 && !doneO) begin
            step();
            n++;
        end
        check("toEdges", n, 64);
        expectO("timeout", 1, 0, 3, 0);
        check("timeout.O.cyc", cycO, 64);

        // completing hit on the timeout cycle wins
        arm(1);
        repeat (63) step();
        check("preTo.O.cyc", cycO, 63);
        check("preTo.O.done", doneO, 0);
        store(104, 25);
        expectO("hitAtTo", 1, 1, 0, 1);
        expectU("hitAtTo", 1, 1, 0, 1);
        check("hitAtTo.O.cyc", cycO, 64);

        // reset mid-run clears outputs and table
        arm(1);
        step(); step();
        doReset();
        expectO("midRst", 0, 0, 0, 0);
        check("midRst.O.cyc", cycO, 0);
        arm(1);
        store(0, 0);
        expectO("tblCleared", 1, 1, 0, 1);

        // zero-length run
        arm(0);
        expectO("len0arm", 0, 0, 0, 0);
        step();
        expectO("len0", 1, 1, 0, 0);
        check("len0.O.cyc", cycO, 1);

        // table writes during RUN are dropped
        doReset();
        load(0, 104, 25);
        arm(1);
        exp_we = 1'b1; exp_idx = 2'd0; exp_addr = 32'd200; exp_data = 32'd9;
        step();
        exp_we = 1'b0;
        store(104, 25);
        expectO("weRun", 1, 1, 0, 1);
        arm(1);
        store(200, 9);
        expectO("weRunRearm", 1, 0, 1, 0);

        // length clamp to DEPTH
        doReset();
        load(0, 20, 1); load(1, 24, 2); load(2, 28, 3); load(3, 32, 4);
        arm(7);
        store(20, 1); store(24, 2); store(28, 3);
        expectO("clamp3", 0, 0, 0, 3);
        store(32, 4);
        expectO("clamp4", 1, 1, 0, 4);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            start      = ($urandom_range(0, 24) == 0);
            exp_we     = ($urandom_range(0, 3) == 0);
            exp_idx    = 2'($urandom_range(0, 3));
            exp_addr   = 32'(104 + 4 * $urandom_range(0, 3));
            exp_data   = 32'($urandom_range(1, 3));
            exp_len    = 3'($urandom_range(0, 7));
            mem_write  = ($urandom_range(0, 2) == 0);
            data_adr   = 32'(100 + 4 * $urandom_range(0, 4));
            write_data = 32'($urandom_range(1, 3));
            step();
        end
        reset = 1'b0; start = 1'b0; exp_we = 1'b0; mem_write = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_seq_checker.md
# store_seq_checker

Synthesisable store-sequence checker for the RISC-V core's self-test flow. Sits beside the core's data-memory port and watches every store (mem_write, data_adr, write_data). It compares the stores against a programmable table of expected (address, data) pairs, tolerates writes to a scratch address, and enforces a cycle timeout. It reports done/pass plus a fail code, so pass/fail no longer depends on a bench-only negedge check.

## Interface
- XLEN, 32: width of data_adr, write_data and table entries
- DEPTH, 4: number of expected-store table entries (≥1)
- TIMEOUT, 64: max cycles in RUN before timeout fail (≥1)
- ORDERED, 1: 1 = stores must hit entries in index order; 0 = any order
- IGNORE_ADDR, 100: scratch address whose stores are always ignored
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_write  in  1  store strobe from the core
- data_adr  in  XLEN  store address
- write_data  in  XLEN  store data
- exp_we  in  1  table write strobe, honoured only in IDLE
- exp_idx  in  $clog2(DEPTH)  table entry index
- exp_addr, exp_data  in  XLEN each  entry contents
- exp_len  in  $clog2(DEPTH)+1  entries to check, latched on start (clamped to DEPTH)
- start  in  1  arm the checker
- done  out  1  in PASS or FAIL
- pass  out  1  in PASS
- fail_code  out  3  0 none, 1 unexpected addr, 2 data mismatch, 3 timeout, 4 out-of-order
- match_count  out  $clog2(DEPTH)+1  entries matched so far
- cycles  out  $clog2(TIMEOUT+1)  cycles spent in RUN

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE, table and all outputs zero, hit mask zero.
- IDLE: exp_we writes the entry. start → RUN, latches len, clears match_count/cycles/hit mask.
- exp_we outside IDLE is ignored.
- start in PASS/FAIL re-arms (→ RUN, same clearing); start in RUN is ignored.
- In RUN with len=0, go to PASS on the next edge.
- A store in RUN (mem_write=1) is classified in priority order:
  - data_adr==IGNORE_ADDR → ignored.
  - ORDERED=1, compared against entry[match_count]:
    - addr and data equal → hit.
    - addr equal, data differs → FAIL 2.
    - addr equals a later entry (index < len) → FAIL 4.
    - otherwise → FAIL 1.
  - ORDERED=0, compared against all entries < len:
    - exact match on an unhit entry → hit, set its mask bit.
    - exact match on a hit entry only → ignored (duplicate).
    - addr matches any entry, data differs → FAIL 2.
    - otherwise → FAIL 1.
  - On duplicate addresses in the table, the lowest unhit index wins.
- hit: match_count+1. match_count reaching len → PASS.
- cycles increments every RUN cycle. Reaching TIMEOUT with no completing hit in that cycle → FAIL 3.
- If a completing hit and the timeout land in the same cycle, the hit wins (PASS).
- PASS/FAIL hold all outputs; stores are ignored there.
- mem_write outside RUN has no effect.

## Timing
- Single-cycle latency: a store sampled at edge N updates match_count/state at N. done/pass/fail_code are visible after edge N.
- The store inputs must be stable at the rising edge. Combinational compare paths are allowed, with no extra pipeline.
- Timeout: done rises at the edge where cycles becomes TIMEOUT, i.e. TIMEOUT edges after entering RUN.
- Reset mid-RUN: IDLE on that edge, table cleared, no done pulse.

## Structure
- Package store_chk_pkg:
  - state enum (IDLE/RUN/PASS/FAIL).
  - fail-code localparams FC_NONE..FC_ORDER.
- Sub-module store_match_unit (combinational, parametrised):
  - Inputs: one store, the table, the hit mask, ptr, len, ORDERED, IGNORE_ADDR.
  - Outputs: hit, hit_idx, ignore, fail_code.
- The top module holds the table, FSM and counters.

## Test plan
- Pass with scratch write (default params):
  - Stimulus: load (104,25), len=1, start; stores (100,7) then (104,25).
  - Response: pass=1 and done=1 after the second store; match_count=1; fail_code=0.
- Unexpected address and data mismatch, each from a fresh start:
  - Store (96,25) → FAIL, fail_code=1.
  - Store (104,24) → FAIL, fail_code=2.
  - In both cases further stores leave the outputs unchanged.
- Ordering (DEPTH=4):
  - Table (8,1),(12,2),(16,3), len=3, stores 16,8,12.
  - ORDERED=1 → FAIL 4 on the first store.
  - ORDERED=0 → PASS after the third store; a repeated (8,1) before completion is ignored.
- Timeout:
  - Start with len=1, no stores → done at exactly 64 cycles, fail_code=3.
  - A (104,25) store on cycle 64 → PASS instead.
- Reset and config:
  - reset mid-RUN → IDLE, all outputs 0.
  - start with len=0 → PASS next cycle.
  - exp_we during RUN does not alter the table (verified after re-arm).
